// File: rtl/pulse_timing_pkg.sv
// Shared types and helpers for the pulse timing generator.
// Holds the FSM state encoding, the default count-field width and the
// width clamp applied when a new pulse configuration is accepted.
package pulse_timing_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Clamp the high time so every period keeps at least one low phase.
    // A one-step period has no room for a low phase, so it never goes high.
    // Arguments are 32 bits wide so any count width up to 32 can use this.
    function automatic logic [31:0] clamp_width(input logic [31:0] period_v,
                                                input logic [31:0] width_v);
        logic [31:0] max_w;
        if (period_v <= 32'd1) begin
            return 32'd0;
        end
        max_w = period_v - 32'd1;
        return (width_v < max_w) ? width_v : max_w;
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Turns the divided clock into single-cycle count steps.
// div_clk_in is already synchronous to CLK, so a single register is enough
// to find its rising edge. Every rising edge is a tick; every TICK_DIV-th
// tick becomes a step. clear restarts the prescaler so a new run always
// begins on a full prescale interval.
module tick_edge_detect #(
    parameter int TICK_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic div_clk_in,
    input  logic clear,
    output logic step
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic            div_clk_q;
    logic [PS_W-1:0] prescale_q;
    logic            tick;

    assign tick = div_clk_in & ~div_clk_q;
    assign step = tick && (prescale_q == PS_LAST);

    // Edge register and prescaler that divides ticks down to steps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_clk_q  <= 1'b0;
            prescale_q <= '0;
        end else begin
            div_clk_q <= div_clk_in;
            if (clear) begin
                prescale_q <= '0;
            end else if (tick) begin
                prescale_q <= (prescale_q == PS_LAST) ? '0 : prescale_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_timing_generator.sv
// Programmable pulse train generator for the pulse-drive output stage.
// Counts steps derived from division_CLK and drives pulse_out high for the
// first width_eff steps of every period_q-step period. Stop is graceful:
// the period in progress always runs to its end before returning to IDLE.
// Optional feature macro: PULSE_BURST_EN adds burst_len/done for automatic
// stop after a fixed number of periods.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | not pulsing; waits for start, rejects period==0 with cfg_err
//  RUN      | pulsing continuously with the configuration latched at start
//  STOPPING | stop seen; finishes the current period, then returns to IDLE
module pulse_timing_generator
    import pulse_timing_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TICK_DIV = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             div_clk_in,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
`ifdef PULSE_BURST_EN
    input  logic [CNT_W-1:0] burst_len,
    output logic             done,
`endif
    output logic             pulse_out,
    output logic             busy,
    output logic [CNT_W-1:0] pulse_count,
    output logic             cfg_err
);

    state_t           state, state_next;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] width_eff_q, width_eff_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] count_d;
    logic             pulse_d;
    logic             cfg_err_d;
    logic             start_ok;
    logic             step;
`ifdef PULSE_BURST_EN
    logic [CNT_W-1:0] burst_len_q, burst_len_d;
    logic             done_d;
`endif

    tick_edge_detect #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK        (CLK),
        .RST        (RST),
        .div_clk_in (div_clk_in),
        .clear      (start_ok),
        .step       (step)
    );

    assign busy = (state != IDLE);

    // Next-state, phase/count update and next output values.
    always_comb begin
        state_next  = state;
        period_d    = period_q;
        width_eff_d = width_eff_q;
        phase_d     = phase_q;
        count_d     = pulse_count;
        cfg_err_d   = 1'b0;
        start_ok    = 1'b0;
`ifdef PULSE_BURST_EN
        burst_len_d = burst_len_q;
`endif

        case (state)
            IDLE: begin
                // stop wins over a simultaneous start, silently
                if (start && !stop) begin
                    if (period == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        start_ok    = 1'b1;
                        state_next  = RUN;
                        period_d    = period;
                        width_eff_d = CNT_W'(clamp_width(32'(period), 32'(width)));
                        phase_d     = '0;
                        count_d     = '0;
`ifdef PULSE_BURST_EN
                        burst_len_d = burst_len;
`endif
                    end
                end
            end
            RUN, STOPPING: begin
                if (state == RUN && stop) begin
                    state_next = STOPPING;
                end
                if (step) begin
                    if (phase_q == period_q - 1'b1) begin
                        phase_d = '0;
                        count_d = pulse_count + 1'b1;
                        if (state == STOPPING) begin
                            state_next = IDLE;
                        end
`ifdef PULSE_BURST_EN
                        if (burst_len_q != '0 && count_d == burst_len_q) begin
                            state_next = IDLE;
                        end
`endif
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        pulse_d = (state_next != IDLE) && (phase_d < width_eff_d);
`ifdef PULSE_BURST_EN
        done_d  = (state != IDLE) && (state_next == IDLE);
`endif
    end

    // State register, latched configuration and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            period_q    <= '0;
            width_eff_q <= '0;
            phase_q     <= '0;
            pulse_count <= '0;
            pulse_out   <= 1'b0;
            cfg_err     <= 1'b0;
`ifdef PULSE_BURST_EN
            burst_len_q <= '0;
            done        <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            period_q    <= period_d;
            width_eff_q <= width_eff_d;
            phase_q     <= phase_d;
            pulse_count <= count_d;
            pulse_out   <= pulse_d;
            cfg_err     <= cfg_err_d;
`ifdef PULSE_BURST_EN
            burst_len_q <= burst_len_d;
            done        <= done_d;
`endif
        end
    end

endmodule
